// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional Gray codec with valid/ready flow control.
// Binary->Gray resolves in stage 1; Gray->binary resolves a chunk of bits per stage, MSB first.
module gray_codec_pipe #(
    parameter int WIDTH   = 4,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_mode,
    output logic [WIDTH-1:0]   o_data,
    output logic [COUNT_W-1:0] o_count
);
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    // Handshake: a beat moves on an edge where valid & ready are both high.
    // The whole pipe advances together when the output slot is empty or being
    // drained, so o_ready never depends on i_valid.
    logic               r_val  [STAGES];
    logic               r_mode [STAGES];
    logic               r_acc  [STAGES];
    logic [WIDTH-1:0]   r_dat  [STAGES];
    logic [COUNT_W-1:0] r_count;

    logic               w_en;
    logic               w_nxt_acc [STAGES];
    logic [WIDTH-1:0]   w_nxt_dat [STAGES];

    // Resolve stage s's chunk: each bit becomes the running XOR from the MSB.
    // Returns {carry, word}; bits below the chunk stay as raw Gray bits.
    function automatic logic [WIDTH:0] resolve(input logic [WIDTH-1:0] d_in,
                                               input logic c_in, input int s);
        logic [WIDTH-1:0] d;
        logic             c;
        int               hi;
        int               lo;
        d  = d_in;
        c  = c_in;
        hi = WIDTH - 1 - s * CHUNK;
        lo = hi - CHUNK + 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                c    = c ^ d[i];
                d[i] = c;
            end
        end
        return {c, d};
    endfunction

    assign w_en    = ~r_val[STAGES-1] | i_ready;
    assign o_ready = w_en;
    assign o_valid = r_val[STAGES-1];
    assign o_mode  = r_mode[STAGES-1];
    assign o_data  = r_dat[STAGES-1];
    assign o_count = r_count;

    always_comb begin
        w_nxt_dat[0] = i_data ^ (i_data >> 1);
        w_nxt_acc[0] = 1'b0;
        if (i_mode) begin
            {w_nxt_acc[0], w_nxt_dat[0]} = resolve(i_data, 1'b0, 0);
        end
        for (int s = 1; s < STAGES; s++) begin
            w_nxt_dat[s] = r_dat[s-1];
            w_nxt_acc[s] = r_acc[s-1];
            if (r_mode[s-1]) begin
                {w_nxt_acc[s], w_nxt_dat[s]} = resolve(r_dat[s-1], r_acc[s-1], s);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_val[s]  <= 1'b0;
                r_mode[s] <= 1'b0;
                r_acc[s]  <= 1'b0;
                r_dat[s]  <= '0;
            end
            r_count <= '0;
        end else begin
            if (w_en) begin
                r_val[0]  <= i_valid;
                r_mode[0] <= i_mode;
                r_acc[0]  <= w_nxt_acc[0];
                r_dat[0]  <= w_nxt_dat[0];
                for (int s = 1; s < STAGES; s++) begin
                    r_val[s]  <= r_val[s-1];
                    r_mode[s] <= r_mode[s-1];
                    r_acc[s]  <= w_nxt_acc[s];
                    r_dat[s]  <= w_nxt_dat[s];
                end
            end
            if (r_val[STAGES-1] & i_ready) begin
                r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: main 4/2 instance, a COUNT_W=4 twin sharing its inputs,
// and an 8-bit/8-stage instance for deep Gray->binary conversion.
module tb_gray_codec_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, i_valid, i_mode, i_ready;
    logic [3:0] i_data;
    wire        o_ready, o_valid, o_mode;
    wire  [3:0] o_data;
    wire [15:0] o_count;

    wire        c_o_ready, c_o_valid, c_o_mode;
    wire  [3:0] c_o_data;
    wire  [3:0] c_o_count;

    logic       w_i_valid, w_i_mode, w_i_ready;
    logic [7:0] w_i_data;
    wire        w_o_ready, w_o_valid, w_o_mode;
    wire  [7:0] w_o_data;
    wire [15:0] w_o_count;

    gray_codec_pipe #(.WIDTH(4), .STAGES(2), .COUNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_mode(o_mode),
        .o_data(o_data), .o_count(o_count));

    gray_codec_pipe #(.WIDTH(4), .STAGES(2), .COUNT_W(4)) dut_cnt (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(c_o_ready), .i_mode(i_mode),
        .i_data(i_data), .o_valid(c_o_valid), .i_ready(i_ready), .o_mode(c_o_mode),
        .o_data(c_o_data), .o_count(c_o_count));

    gray_codec_pipe #(.WIDTH(8), .STAGES(8), .COUNT_W(16)) dut_wide (
        .i_clk(clk), .i_rst(rst), .i_valid(w_i_valid), .o_ready(w_o_ready), .i_mode(w_i_mode),
        .i_data(w_i_data), .o_valid(w_o_valid), .i_ready(w_i_ready), .o_mode(w_o_mode),
        .o_data(w_o_data), .o_count(w_o_count));

    int total = 0;
    int bad = 0;
    int n_xfer = 0;
    int w_xfer = 0;
    logic done_flag = 1'b0;
    logic [4:0] exp_q[$];
    logic [8:0] wexp_q[$];
    logic [3:0] g_tab[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int k = 1; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [3:0] model4(input logic m, input logic [3:0] d);
        return m ? 4'(g2b({4'b0, d})) : 4'(b2g({4'b0, d}));
    endfunction

    // Scoreboard and hold-stability monitor for the main instance
    logic       hold_v = 1'b0;
    logic [4:0] hold_d;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {o_mode, o_data}, hold_d);
            hold_v = o_valid & ~i_ready;
            hold_d = {o_mode, o_data};
            if (o_valid && i_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
                else chk("out_word", {o_mode, o_data}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w_o_valid && w_i_ready) begin
            w_xfer++;
            if (wexp_q.size() == 0) chk("wide_unexpected", wexp_q.size(), 1);
            else chk("wide_word", {w_o_mode, w_o_data}, wexp_q.pop_front());
        end
    end

    task automatic send(input logic m, input logic [3:0] d, input logic [3:0] e);
        int   budget;
        logic acc;
        budget = 0;
        acc = 1'b0;
        i_valid = 1'b1; i_mode = m; i_data = d;
        while (!acc) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            if (acc) exp_q.push_back({m, e});
            else if (++budget > 50) begin
                chk("send_timeout", budget, 0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic wsend(input logic m, input logic [7:0] d);
        int   budget;
        logic acc;
        budget = 0;
        acc = 1'b0;
        w_i_valid = 1'b1; w_i_mode = m; w_i_data = d;
        while (!acc) begin
            @(negedge clk);
            acc = w_o_ready;
            @(posedge clk); #1;
            if (acc) wexp_q.push_back({m, m ? g2b(d) : b2g(d)});
            else if (++budget > 50) begin
                chk("wsend_timeout", budget, 0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || wexp_q.size() != 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_left", exp_q.size() + wexp_q.size(), 0);
    endtask

    initial begin
        #400000;
        chk("watchdog_done", done_flag, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic       m;
        logic [3:0] d;
        logic [7:0] wd;
        int         k;
        g_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ready = 1'b1;
        w_i_valid = 1'b0; w_i_mode = 1'b1; w_i_data = '0; w_i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_data", o_data, 0);
        chk("rst_cnt4", c_o_count, 0);

        // Latency: accepted at edge N, valid after edge N+1
        i_valid = 1'b1; i_mode = 1'b0; i_data = 4'b0101;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 4'b0111});
        i_valid = 1'b0;
        chk("lat_not_yet", o_valid, 0);
        @(posedge clk); #1;
        chk("lat_n_plus_1", o_valid, 1);

        // All 16 codes, bin->gray, against a fixed table
        for (int v = 0; v < 16; v++) send(1'b0, 4'(v), g_tab[v]);
        i_valid = 1'b0;
        drain();
        chk("count_17", o_count, 17);
        chk("count_model", o_count, n_xfer);
        chk("cnt4_wrapped", c_o_count, 1);

        // Gray->bin fixed vectors, then alternating modes
        send(1'b1, 4'b1110, 4'b1011);
        send(1'b1, 4'b1000, 4'b1111);
        send(1'b1, 4'b0000, 4'b0000);
        for (int j = 0; j < 12; j++) begin
            m = 1'(j & 1);
            d = 4'($urandom_range(0, 15));
            send(m, d, model4(m, d));
        end
        i_valid = 1'b0;
        drain();

        // Backpressure with a full pipe
        i_ready = 1'b0;
        send(1'b0, 4'h3, g_tab[3]);
        send(1'b1, 4'h9, 4'hE);
        i_valid = 1'b1; i_mode = 1'b0; i_data = 4'hA;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_ready", o_ready, 0);
            chk("stall_data", {o_mode, o_data}, {1'b0, g_tab[3]});
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        send(1'b0, 4'hA, g_tab[10]);
        i_valid = 1'b0;
        drain();
        chk("count_after_stall", o_count, n_xfer);

        // Reset with two beats in flight
        i_ready = 1'b0;
        send(1'b0, 4'h5, g_tab[5]);
        send(1'b0, 4'h6, g_tab[6]);
        i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        n_xfer = 0;
        rst = 1'b0;
        i_ready = 1'b1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_count", o_count, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_cnt4", c_o_count, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_ghost", n_xfer, 0);
        send(1'b1, 4'b1000, 4'b1111);
        i_valid = 1'b0;
        drain();
        chk("post_rst_count", o_count, 1);

        // Wide instance: latency 8 then random mixed stream
        wd = 8'($urandom_range(0, 255));
        w_i_valid = 1'b1; w_i_mode = 1'b1; w_i_data = wd;
        @(posedge clk); #1;
        wexp_q.push_back({1'b1, g2b(wd)});
        w_i_valid = 1'b0;
        k = 0;
        while (!w_o_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wide_latency", k, 7);
        for (int j = 0; j < 24; j++) begin
            m = (j % 4 == 3) ? 1'b0 : 1'b1;
            wsend(m, 8'($urandom_range(0, 255)));
        end
        w_i_valid = 1'b0;
        drain();
        chk("wide_count", w_o_count, w_xfer);
        chk("wide_count_abs", w_o_count, 25);

        done_flag = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
